arbiter_mux_32_8: RTL

- Round-robin scheduler that shares the 32-to-8 byte serialization datapath between two 32-bit word FIFOs, lane 0 and lane 1.
- Pops one word at a time from the granted FIFO and emits it as four bytes on clk_4f, MSB first. This matches the byte order the 8-to-32 demux reassembles.
- Prefetches the next word during the current word so back-to-back words stream with no gap.
- Emits the idle symbol with valid low when no word is in flight.

---
 rtl/arbiter_mux_32_8.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/arbiter_mux_32_8.sv
// Round-robin arbiter sharing a 32-to-8 byte serializer between two word FIFOs.
// Words are emitted MSB first, one byte per clk_4f, with the next word
// prefetched during the current one so consecutive words stream without a gap.
module arbiter_mux_32_8 #(
  parameter logic [7:0] IDLE_SYMBOL = 8'hBC
) (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic [31:0] fifo0_data_out,
  input  logic        fifo0_empty,
  input  logic [31:0] fifo1_data_out,
  input  logic        fifo1_empty,
  input  logic        stall,
  output logic        pop0,
  output logic        pop1,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic        lane_out,
  output logic        busy
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_POP   = 2'd1,
    ST_FETCH = 2'd2,
    ST_SEND  = 2'd3
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                rr_ptr_q;
  logic                gnt_lane_q;
  logic                pend_q;
  logic [WORD_W-1:0]   shift_q;
  logic                pop0_q;
  logic                pop1_q;
  logic [BYTE_W-1:0]   data_q;
  logic                valid_q;
  logic                lane_q;
  logic                busy_q;

  logic                elig0_c;
  logic                elig1_c;
  logic                grant_c;
  logic                grant_lane_c;
  logic [WORD_W-1:0]   fetch_word_c;

  // Eligibility and round-robin pick; stall suppresses any new grant.
  always_comb begin
    elig0_c      = !fifo0_empty && !stall;
    elig1_c      = !fifo1_empty && !stall;
    grant_c      = elig0_c || elig1_c;
    grant_lane_c = (elig0_c && elig1_c) ? rr_ptr_q : elig1_c;
    fetch_word_c = gnt_lane_q ? fifo1_data_out : fifo0_data_out;
  end

  // Scheduler FSM with registered strobes and byte outputs.
  always_ff @(posedge clk_4f) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rr_ptr_q   <= 1'b0;
      gnt_lane_q <= 1'b0;
      pend_q     <= 1'b0;
      shift_q    <= '0;
      pop0_q     <= 1'b0;
      pop1_q     <= 1'b0;
      data_q     <= IDLE_SYMBOL;
      valid_q    <= 1'b0;
      lane_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      pop0_q <= 1'b0;
      pop1_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          valid_q <= 1'b0;
          data_q  <= IDLE_SYMBOL;
          if (grant_c) begin
            state_q    <= ST_POP;
            busy_q     <= 1'b1;
            gnt_lane_q <= grant_lane_c;
            rr_ptr_q   <= ~grant_lane_c;
            pop0_q     <= ~grant_lane_c;
            pop1_q     <= grant_lane_c;
          end
        end
        ST_POP: begin
          state_q <= ST_FETCH;
        end
        ST_FETCH: begin
          state_q <= ST_SEND;
          cnt_q   <= '0;
          shift_q <= {fetch_word_c[WORD_W-BYTE_W-1:0], BYTE_W'(0)};
          data_q  <= fetch_word_c[WORD_W-1 -: BYTE_W];
          valid_q <= 1'b1;
          lane_q  <= gnt_lane_q;
        end
        ST_SEND: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(3)) begin
            if (pend_q) begin
              // Back-to-back: load the prefetched word without a bubble.
              pend_q  <= 1'b0;
              shift_q <= {fetch_word_c[WORD_W-BYTE_W-1:0], BYTE_W'(0)};
              data_q  <= fetch_word_c[WORD_W-1 -: BYTE_W];
              valid_q <= 1'b1;
              lane_q  <= gnt_lane_q;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              valid_q <= 1'b0;
              data_q  <= IDLE_SYMBOL;
            end
          end else begin
            data_q  <= shift_q[WORD_W-1 -: BYTE_W];
            shift_q <= {shift_q[WORD_W-BYTE_W-1:0], BYTE_W'(0)};
            if (cnt_q == CNT_W'(1) && grant_c) begin
              pend_q     <= 1'b1;
              gnt_lane_q <= grant_lane_c;
              rr_ptr_q   <= ~grant_lane_c;
              pop0_q     <= ~grant_lane_c;
              pop1_q     <= grant_lane_c;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pop0      = pop0_q;
  assign pop1      = pop1_q;
  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign lane_out  = lane_q;
  assign busy      = busy_q;

endmodule
